// File: rtl/dmem_subword_ctrl.sv
// dmem_subword_ctrl: word/half/byte load-store sequencer over a word-wide sync-read memory.
// Define DMEM_ALIGN_CHECK_EN to add the err port and reject misaligned accesses.
module dmem_subword_ctrl #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    ctrl,
  input  logic [31:0]   a,
  input  logic [31:0]   wd,
  output logic [31:0]   rd,
  output logic          stall,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic          err,
`endif
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);
  typedef enum logic [1:0] {IDLE, LD_RSP, ST_RMW} state_t;
  state_t r_state, w_next;
  logic [1:0] r_lane, r_ctrl;
  logic [AW-1:0] r_addr;
  logic [15:0] r_wd;
  logic w_mis, w_go, w_word_st, w_unused;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask, w_ins;
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis = (ctrl == 2'b01 && a[0]) || (ctrl == 2'b00 && a[1:0] != 2'b00);
  assign err = !reset && r_state == IDLE && req && w_mis;
`else
  assign w_mis = 1'b0;
`endif
  assign w_unused = ^a[31:AW+2];
  assign w_go = !reset && r_state == IDLE && req && !w_mis;
  assign w_word_st = we && ctrl == 2'b00;
  assign w_byte = 8'(mem_rd >> {r_lane, 3'b000});
  assign w_half = r_lane[1] ? mem_rd[31:16] : mem_rd[15:0];
  // merge mask/data for the read-modify-write lane replacement
  assign w_mask = r_ctrl == 2'b01 ? (r_lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF)
                                  : 32'h0000_00FF << {r_lane, 3'b000};
  assign w_ins = r_ctrl == 2'b01 ? {2{r_wd}} : {4{r_wd[7:0]}};
  always_comb begin
    w_next = r_state;
    stall = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
    mem_wd = '0;
    mem_a = '0;
    rd = '0;
    if (!reset) begin
      mem_a = r_state == ST_RMW ? r_addr : a[AW+1:2];
      if (w_go && w_word_st) begin
        mem_we = 1'b1;
        mem_wd = wd;
      end else if (w_go) begin
        mem_re = 1'b1;
        stall = 1'b1;
        w_next = we ? ST_RMW : LD_RSP;
      end
      if (r_state == LD_RSP) begin
        rd = r_ctrl == 2'b00 ? mem_rd
           : r_ctrl == 2'b01 ? {{16{w_half[15]}}, w_half}
           : {{24{w_byte[7] & ~r_ctrl[0]}}, w_byte};
        w_next = IDLE;
      end
      if (r_state == ST_RMW) begin
        mem_we = 1'b1;
        mem_wd = (mem_rd & ~w_mask) | (w_ins & w_mask);
        w_next = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_lane <= '0;
      r_ctrl <= '0;
      r_addr <= '0;
      r_wd <= '0;
    end else begin
      r_state <= w_next;
      if (w_go && !w_word_st) begin
        r_lane <= a[1:0];
        r_ctrl <= ctrl;
        r_addr <= a[AW+1:2];
        r_wd <= wd[15:0];
      end
    end
  end
endmodule
